// File: rtl/regfile_multiport_pkg.sv
// Shared types and width helpers for the multiport register file.
package regfile_multiport_pkg;

    typedef enum logic {
        RfStClear,
        RfStRun
    } rf_state_e;

    function automatic int sel_w_of(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    function automatic int bus_w_of(input int ports, input int width);
        return ports * width;
    endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Read/write/reservation bus of the multiport register file.
interface regfile_multiport_if
    import regfile_multiport_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 3
);
    localparam int SEL_W = sel_w_of(NUM_REGS);

    logic [NUM_RD-1:0]                       rd_en;
    logic [NUM_RD*SEL_W-1:0]                 rd_sel;
    logic [bus_w_of(NUM_RD, DATA_WIDTH)-1:0] rd_data;
    logic [NUM_RD-1:0]                       rd_pending;
    logic                                    wr_en;
    logic [SEL_W-1:0]                        wr_sel;
    logic [DATA_WIDTH-1:0]                   wr_data;
    logic                                    rsv_en;
    logic [SEL_W-1:0]                        rsv_sel;
    logic                                    ready;

    modport master (
        output rd_en, rd_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel,
        input  rd_data, rd_pending, ready
    );

    modport slave (
        input  rd_en, rd_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel,
        output rd_data, rd_pending, ready
    );

endinterface

// File: rtl/regfile_multiport_scoreboard.sv
// Per-register pending-write bits: reservation sets, write clears, set wins on a tie.
module reg_scoreboard
    import regfile_multiport_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ZERO_REG = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [sel_w_of(NUM_REGS)-1:0] wr_sel,
    input  logic                          rsv_en,
    input  logic [sel_w_of(NUM_REGS)-1:0] rsv_sel,
    output logic [NUM_REGS-1:0]           pending_cur,
    output logic [NUM_REGS-1:0]           pending_next
);
    logic [NUM_REGS-1:0] pending_q;

    always_comb begin
        pending_next = pending_q;
        if (wr_en) pending_next[wr_sel] = 1'b0;
        if (rsv_en) pending_next[rsv_sel] = 1'b1;
        if (ZERO_REG != 0) pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_next;
    end

    assign pending_cur = pending_q;

endmodule

// File: rtl/regfile_multiport.sv
// Register file with N registered read ports, one write port, post-reset clear
// engine and pending-write scoreboard.
module regfile_multiport
    import regfile_multiport_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 3,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input logic                clk,
    input logic                rst,
    regfile_multiport_if.slave bus
);
    localparam int SEL_W = sel_w_of(NUM_REGS);

    typedef struct packed {
        logic                  wr_en;
        logic [SEL_W-1:0]      wr_sel;
        logic [DATA_WIDTH-1:0] wr_data;
        logic                  rsv_en;
        logic [SEL_W-1:0]      rsv_sel;
    } wr_port_t;

    wr_port_t              wp;
    rf_state_e             state_q, state_d;
    logic [SEL_W-1:0]      idx_q, idx_d;
    logic                  run;
    logic                  mem_we;
    logic [SEL_W-1:0]      mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_cur, pending_next;
    logic [SEL_W-1:0]      rd_sel_c [NUM_RD];
    logic [DATA_WIDTH-1:0] rd_word_c [NUM_RD];
    logic [NUM_RD-1:0]     rd_pend_c;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_p1;
    logic [NUM_RD-1:0]            rd_pending_p1;

    assign wp  = '{wr_en: bus.wr_en, wr_sel: bus.wr_sel, wr_data: bus.wr_data,
                   rsv_en: bus.rsv_en, rsv_sel: bus.rsv_sel};
    assign run = (state_q == RfStRun);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RfStClear;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mem_we    = 1'b0;
        mem_addr  = wp.wr_sel;
        mem_wdata = wp.wr_data;
        case (state_q)
            RfStClear: begin
                mem_we    = 1'b1;
                mem_addr  = idx_q;
                mem_wdata = '0;
                idx_d     = idx_q + 1'b1;
                if (idx_q == SEL_W'(NUM_REGS - 1)) begin
                    state_d = RfStRun;
                    idx_d   = '0;
                end
            end
            RfStRun: mem_we = wp.wr_en && !((ZERO_REG != 0) && (wp.wr_sel == '0));
            default: state_d = RfStClear;
        endcase
        // A write or clear step coinciding with rst is dropped.
        if (rst) mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wp.wr_en && run),
        .wr_sel       (wp.wr_sel),
        .rsv_en       (wp.rsv_en && run),
        .rsv_sel      (wp.rsv_sel),
        .pending_cur  (pending_cur),
        .pending_next (pending_next)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_sel
        assign rd_sel_c[p] = bus.rd_sel[p*SEL_W +: SEL_W];
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_word_c[p] = '0;
            rd_pend_c[p] = 1'b0;
            if (run && !((ZERO_REG != 0) && (rd_sel_c[p] == '0))) begin
                if ((BYPASS != 0) && wp.wr_en && (wp.wr_sel == rd_sel_c[p]))
                    rd_word_c[p] = wp.wr_data;
                else
                    rd_word_c[p] = mem[rd_sel_c[p]];
                rd_pend_c[p] = (BYPASS != 0) ? pending_next[rd_sel_c[p]]
                                             : pending_cur[rd_sel_c[p]];
            end
        end
    end

    // Stage p1: registered read ports; disabled ports hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_p1    <= '0;
            rd_pending_p1 <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (bus.rd_en[p]) begin
                    rd_data_p1[p*DATA_WIDTH +: DATA_WIDTH] <= rd_word_c[p];
                    rd_pending_p1[p]                       <= rd_pend_c[p];
                end
            end
        end
    end

    assign bus.rd_data    = rd_data_p1;
    assign bus.rd_pending = rd_pending_p1;
    assign bus.ready      = run;

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: directed vector table, reset-mid-clear sequence and
// random traffic, all checked against a behavioural model of both configurations.
module tb_regfile_multiport;

    localparam int NR = 16;
    localparam int NP = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rd_en;
    logic [11:0] rd_sel;
    logic        wr_en;
    logic [3:0]  wr_sel;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [3:0]  rsv_sel;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    regfile_multiport_if #(.NUM_REGS(NR), .DATA_WIDTH(32), .NUM_RD(NP)) bus_a ();
    regfile_multiport_if #(.NUM_REGS(NR), .DATA_WIDTH(32), .NUM_RD(NP)) bus_b ();

    assign bus_a.rd_en = rd_en;   assign bus_b.rd_en = rd_en;
    assign bus_a.rd_sel = rd_sel; assign bus_b.rd_sel = rd_sel;
    assign bus_a.wr_en = wr_en;   assign bus_b.wr_en = wr_en;
    assign bus_a.wr_sel = wr_sel; assign bus_b.wr_sel = wr_sel;
    assign bus_a.wr_data = wr_data; assign bus_b.wr_data = wr_data;
    assign bus_a.rsv_en = rsv_en; assign bus_b.rsv_en = rsv_en;
    assign bus_a.rsv_sel = rsv_sel; assign bus_b.rsv_sel = rsv_sel;

    // dut_a: bypass + hardwired zero; dut_b: no bypass, reg 0 ordinary.
    regfile_multiport #(.NUM_REGS(NR), .DATA_WIDTH(32), .NUM_RD(NP), .BYPASS(1), .ZERO_REG(1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    regfile_multiport #(.NUM_REGS(NR), .DATA_WIDTH(32), .NUM_RD(NP), .BYPASS(0), .ZERO_REG(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Behavioural model, one slot per DUT.
    int          m_edges [2];
    logic [31:0] m_mem   [2][NR];
    bit          m_pend  [2][NR];
    logic [31:0] e_data  [2][NP];
    bit          e_pend  [2][NP];
    bit          e_rdy   [2];

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit byp = (d == 0);
            bit zr  = (d == 0);
            if (rst) begin
                m_edges[d] = 0;
                for (int r = 0; r < NR; r++) m_pend[d][r] = 1'b0;
                for (int p = 0; p < NP; p++) begin
                    e_data[d][p] = '0;
                    e_pend[d][p] = 1'b0;
                end
                e_rdy[d] = 1'b0;
            end else begin
                bit running = (m_edges[d] >= NR);
                bit npend [NR];
                bit wr_ok  = wr_en && !(zr && wr_sel == 4'd0);
                bit rsv_ok = rsv_en && !(zr && rsv_sel == 4'd0);
                for (int r = 0; r < NR; r++) npend[r] = m_pend[d][r];
                if (running && wr_ok) npend[wr_sel] = 1'b0;
                if (running && rsv_ok) npend[rsv_sel] = 1'b1;
                for (int p = 0; p < NP; p++) begin
                    if (rd_en[p]) begin
                        logic [3:0] s = rd_sel[p*4 +: 4];
                        if (!running || (zr && s == 4'd0)) begin
                            e_data[d][p] = '0;
                            e_pend[d][p] = 1'b0;
                        end else begin
                            e_data[d][p] = (byp && wr_en && wr_sel == s) ? wr_data : m_mem[d][s];
                            e_pend[d][p] = byp ? npend[s] : m_pend[d][s];
                        end
                    end
                end
                if (!running) begin
                    m_mem[d][m_edges[d]] = '0;
                    m_edges[d]++;
                end else if (wr_ok) begin
                    m_mem[d][wr_sel] = wr_data;
                end
                for (int r = 0; r < NR; r++) m_pend[d][r] = npend[r];
                e_rdy[d] = (m_edges[d] >= NR);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] act_data(input int d, input int p);
        return (d == 0) ? bus_a.rd_data[p*32 +: 32] : bus_b.rd_data[p*32 +: 32];
    endfunction

    function automatic logic act_pend(input int d, input int p);
        return (d == 0) ? bus_a.rd_pending[p] : bus_b.rd_pending[p];
    endfunction

    task automatic check_model();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NP; p++) begin
                chk($sformatf("dut%0d.port%0d.data", d, p), act_data(d, p), e_data[d][p]);
                chk($sformatf("dut%0d.port%0d.pend", d, p), 32'(act_pend(d, p)), 32'(e_pend[d][p]));
            end
            chk($sformatf("dut%0d.ready", d), (d == 0) ? 32'(bus_a.ready) : 32'(bus_b.ready),
                32'(e_rdy[d]));
        end
    endtask

    task automatic drive(input bit r, input logic [2:0] re, input logic [11:0] rs,
                         input bit we, input logic [3:0] ws, input logic [31:0] wd,
                         input bit ve, input logic [3:0] vs);
        @(negedge clk);
        rst = r; rd_en = re; rd_sel = rs; wr_en = we; wr_sel = ws; wr_data = wd;
        rsv_en = ve; rsv_sel = vs;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    function automatic logic [11:0] rep(input logic [3:0] s);
        return {s, s, s};
    endfunction

    typedef struct {
        bit          r;
        logic [2:0]  re;
        logic [11:0] rs;
        bit          we;
        logic [3:0]  ws;
        logic [31:0] wd;
        bit          ve;
        logic [3:0]  vs;
        logic [31:0] exp_d0;
        bit          exp_p0;
        bit          exp_rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input logic [2:0] re, input logic [3:0] s,
                       input bit we, input logic [3:0] ws, input logic [31:0] wd,
                       input bit ve, input logic [3:0] vs,
                       input logic [31:0] ed, input bit ep, input bit er);
        vec_t v;
        v = '{r: r, re: re, rs: rep(s), we: we, ws: ws, wd: wd, ve: ve, vs: vs,
              exp_d0: ed, exp_p0: ep, exp_rdy: er};
        tbl.push_back(v);
    endtask

    initial begin
        int n;
        rst = 1'b1; rd_en = '0; rd_sel = '0; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_sel = '0;
        for (int d = 0; d < 2; d++) begin
            m_edges[d] = 0;
            e_rdy[d] = 1'b0;
            for (int r = 0; r < NR; r++) begin
                m_mem[d][r] = '0;
                m_pend[d][r] = 1'b0;
            end
            for (int p = 0; p < NP; p++) begin
                e_data[d][p] = '0;
                e_pend[d][p] = 1'b0;
            end
        end

        // Expected columns refer to dut_a (bypass, zero reg), port 0.
        add(1, 3'b000, 4'd0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0);
        add(1, 3'b000, 4'd0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0);
        for (int i = 0; i < NR; i++)
            add(0, 3'b111, 4'd5, 1, 4'd5, 32'h111, 1, 4'd5, 32'h0, 0, i == NR - 1);
        add(0, 3'b000, 4'd0, 1, 4'd5, 32'hDEADBEEF, 0, 4'd0, 32'h0,        0, 1);
        add(0, 3'b111, 4'd5, 0, 4'd0, 32'h0,        0, 4'd0, 32'hDEADBEEF, 0, 1);
        add(0, 3'b111, 4'd7, 1, 4'd7, 32'h12345678, 0, 4'd0, 32'h12345678, 0, 1);
        add(0, 3'b111, 4'd7, 0, 4'd0, 32'h0,        0, 4'd0, 32'h12345678, 0, 1);
        add(0, 3'b000, 4'd0, 1, 4'd0, 32'hFFFFFFFF, 0, 4'd0, 32'h12345678, 0, 1);
        add(0, 3'b111, 4'd0, 0, 4'd0, 32'h0,        0, 4'd0, 32'h0,        0, 1);
        add(0, 3'b111, 4'd0, 0, 4'd0, 32'h0,        1, 4'd0, 32'h0,        0, 1);
        add(0, 3'b000, 4'd0, 0, 4'd0, 32'h0,        1, 4'd3, 32'h0,        0, 1);
        add(0, 3'b111, 4'd3, 0, 4'd0, 32'h0,        0, 4'd0, 32'h0,        1, 1);
        add(0, 3'b111, 4'd3, 1, 4'd3, 32'h0000CAFE, 0, 4'd0, 32'h0000CAFE, 0, 1);
        add(0, 3'b111, 4'd3, 1, 4'd3, 32'h0000BEEF, 1, 4'd3, 32'h0000BEEF, 1, 1);
        add(0, 3'b111, 4'd3, 0, 4'd0, 32'h0,        0, 4'd0, 32'h0000BEEF, 1, 1);
        add(0, 3'b000, 4'd0, 1, 4'd9, 32'hA5A5A5A5, 0, 4'd0, 32'h0000BEEF, 1, 1);
        add(0, 3'b111, 4'd9, 0, 4'd0, 32'h0,        0, 4'd0, 32'hA5A5A5A5, 0, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].re, tbl[i].rs, tbl[i].we, tbl[i].ws, tbl[i].wd,
                  tbl[i].ve, tbl[i].vs);
            tick();
            chk($sformatf("tbl%0d.data", i), bus_a.rd_data[31:0], tbl[i].exp_d0);
            chk($sformatf("tbl%0d.pend", i), 32'(bus_a.rd_pending[0]), 32'(tbl[i].exp_p0));
            chk($sformatf("tbl%0d.ready", i), 32'(bus_a.ready), 32'(tbl[i].exp_rdy));
        end

        // Reset, partial clear up to idx 4, reset again, then time the full clear.
        drive(1, 3'b000, 12'h0, 1, 4'd9, 32'h55, 1, 4'd9);
        tick();
        chk("midclr.rst_ready", 32'(bus_a.ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 3'b111, rep(4'd9), 0, 4'd0, 32'h0, 0, 4'd0);
            tick();
        end
        drive(1, 3'b000, 12'h0, 0, 4'd0, 32'h0, 0, 4'd0);
        tick();
        drive(0, 3'b000, 12'h0, 0, 4'd0, 32'h0, 0, 4'd0);
        n = 0;
        while (!bus_a.ready && n < 40) begin
            tick();
            n++;
        end
        chk("midclr.ready_edges", 32'(n), 32'd16);
        drive(0, 3'b111, rep(4'd9), 0, 4'd0, 32'h0, 0, 4'd0);
        tick();
        chk("midclr.reg9_cleared", bus_a.rd_data[95:64], 32'h0);
        drive(0, 3'b000, 12'h0, 1, 4'd9, 32'h77, 0, 4'd0);
        tick();
        chk("hold.port1", bus_b.rd_data[63:32], 32'h0);
        drive(0, 3'b010, rep(4'd9), 0, 4'd0, 32'h0, 0, 4'd0);
        tick();
        chk("hold.read9", bus_b.rd_data[63:32], 32'h77);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 59) == 0), 3'($urandom), 12'($urandom),
                  ($urandom_range(0, 1) == 1), 4'($urandom), $urandom,
                  ($urandom_range(0, 3) == 0), 4'($urandom));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
